// File: rtl/score_keeper.sv
// Score and win detection: counts qualified tank hits per player during the game
// screen, applies a per-player post-hit holdoff, and raises the win-screen code.
module score_keeper #(
   parameter int unsigned LIVES       = 3,
   parameter int unsigned HIT_HOLDOFF = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic       hit_p1,
   input  logic       hit_p2,
   input  logic       reset_plyrScrn,
   output logic [1:0] player_screen,
   output logic [3:0] lives_p1,
   output logic [3:0] lives_p2,
   output logic       round_draw
);

   localparam int unsigned LIVES_W = 4;
   localparam int unsigned HOLD_W  = 8;

   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HIT_HOLDOFF);
   localparam logic [HOLD_W-1:0]  HOLD_ZERO  = '0;
   localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

   localparam logic [1:0] MODE_MENU = 2'b00;
   localparam logic [1:0] MODE_GAME = 2'b01;

   localparam logic [1:0] SCR_NONE = 2'b00;
   localparam logic [1:0] SCR_P1   = 2'b01;
   localparam logic [1:0] SCR_P2   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_P1WIN = 3'd2,
      ST_P2WIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [LIVES_W-1:0]  lives_p1_d, lives_p2_d;
   logic [HOLD_W-1:0]   hold_p1_q, hold_p1_d;
   logic [HOLD_W-1:0]   hold_p2_q, hold_p2_d;
   logic                hit_p1_q, hit_p2_q;
   logic [1:0]          screen_d;
   logic                draw_d;

   logic                hit_p1_cnt, hit_p2_cnt;
   logic [LIVES_W-1:0]  lives_p1_dec, lives_p2_dec;

   // A hit counts on a rising edge, in PLAY only, and only once the holdoff has expired.
   assign hit_p1_cnt = (state_q == ST_PLAY) && hit_p1 && !hit_p1_q && (hold_p1_q == HOLD_ZERO);
   assign hit_p2_cnt = (state_q == ST_PLAY) && hit_p2 && !hit_p2_q && (hold_p2_q == HOLD_ZERO);

   assign lives_p1_dec = lives_p1 - {{(LIVES_W-1){1'b0}}, hit_p1_cnt};
   assign lives_p2_dec = lives_p2 - {{(LIVES_W-1){1'b0}}, hit_p2_cnt};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         lives_p1      <= LIVES_INIT;
         lives_p2      <= LIVES_INIT;
         hold_p1_q     <= HOLD_ZERO;
         hold_p2_q     <= HOLD_ZERO;
         hit_p1_q      <= 1'b0;
         hit_p2_q      <= 1'b0;
         player_screen <= SCR_NONE;
         round_draw    <= 1'b0;
      end else begin
         state_q       <= state_d;
         lives_p1      <= lives_p1_d;
         lives_p2      <= lives_p2_d;
         hold_p1_q     <= hold_p1_d;
         hold_p2_q     <= hold_p2_d;
         hit_p1_q      <= hit_p1;
         hit_p2_q      <= hit_p2;
         player_screen <= screen_d;
         round_draw    <= draw_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lives_p1_d = lives_p1;
      lives_p2_d = lives_p2;
      hold_p1_d  = (hold_p1_q != HOLD_ZERO) ? hold_p1_q - HOLD_ONE : HOLD_ZERO;
      hold_p2_d  = (hold_p2_q != HOLD_ZERO) ? hold_p2_q - HOLD_ONE : HOLD_ZERO;
      screen_d   = player_screen;
      draw_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            lives_p1_d = LIVES_INIT;
            lives_p2_d = LIVES_INIT;
            hold_p1_d  = HOLD_ZERO;
            hold_p2_d  = HOLD_ZERO;
            screen_d   = SCR_NONE;
            if (mode == MODE_GAME) begin
               state_d = ST_PLAY;
            end
         end

         ST_PLAY: begin
            lives_p1_d = lives_p1_dec;
            lives_p2_d = lives_p2_dec;
            if (hit_p1_cnt) hold_p1_d = HOLD_INIT;
            if (hit_p2_cnt) hold_p2_d = HOLD_INIT;

            // Simultaneous last lives: no winner, restart the round in place.
            if (lives_p1_dec == '0 && lives_p2_dec == '0) begin
               draw_d     = 1'b1;
               lives_p1_d = LIVES_INIT;
               lives_p2_d = LIVES_INIT;
               hold_p1_d  = HOLD_ZERO;
               hold_p2_d  = HOLD_ZERO;
            end else if (lives_p1_dec == '0) begin
               state_d  = ST_P2WIN;
               screen_d = SCR_P2;
            end else if (lives_p2_dec == '0) begin
               state_d  = ST_P1WIN;
               screen_d = SCR_P1;
            end else if (mode != MODE_GAME) begin
               state_d    = ST_IDLE;
               lives_p1_d = LIVES_INIT;
               lives_p2_d = LIVES_INIT;
               hold_p1_d  = HOLD_ZERO;
               hold_p2_d  = HOLD_ZERO;
            end
         end

         ST_P1WIN, ST_P2WIN: begin
            if (reset_plyrScrn) begin
               state_d  = ST_DONE;
               screen_d = SCR_NONE;
            end
         end

         ST_DONE: begin
            screen_d = SCR_NONE;
            if (mode == MODE_MENU) begin
               state_d    = ST_IDLE;
               lives_p1_d = LIVES_INIT;
               lives_p2_d = LIVES_INIT;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            screen_d = SCR_NONE;
         end
      endcase
   end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed vector table, hand-written reset/win sequences,
// then randomized play against a timestamp-based reference model.
module tb_score_keeper;

   localparam int unsigned L = 3;
   localparam int unsigned H = 16;

   localparam int PH_IDLE = 0;
   localparam int PH_PLAY = 1;
   localparam int PH_P1W  = 2;
   localparam int PH_P2W  = 3;
   localparam int PH_DONE = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] mode;
   logic       hit_p1, hit_p2, reset_plyrScrn;
   logic [1:0] player_screen;
   logic [3:0] lives_p1, lives_p2;
   logic       round_draw;

   always #5 clk = ~clk;

   score_keeper #(.LIVES(L), .HIT_HOLDOFF(H)) dut (
      .clk            (clk),
      .reset          (reset),
      .mode           (mode),
      .hit_p1         (hit_p1),
      .hit_p2         (hit_p2),
      .reset_plyrScrn (reset_plyrScrn),
      .player_screen  (player_screen),
      .lives_p1       (lives_p1),
      .lives_p2       (lives_p2),
      .round_draw     (round_draw)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: holdoff expressed as the cycle of the last counted hit.
   int m_phase, m_l1, m_l2, m_scr, m_draw, m_cyc, m_last1, m_last2;
   logic m_prev1, m_prev2;

   function automatic void model_reset();
      m_phase = PH_IDLE; m_l1 = L; m_l2 = L; m_scr = 0; m_draw = 0;
      m_last1 = -1000; m_last2 = -1000; m_prev1 = 1'b0; m_prev2 = 1'b0;
   endfunction

   function automatic void model_edge();
      bit c1, c2;
      m_cyc++;
      m_draw = 0;
      c1 = (m_phase == PH_PLAY) && hit_p1 && !m_prev1 && (m_cyc - m_last1 > int'(H));
      c2 = (m_phase == PH_PLAY) && hit_p2 && !m_prev2 && (m_cyc - m_last2 > int'(H));
      case (m_phase)
         PH_IDLE: begin
            m_l1 = L; m_l2 = L; m_last1 = -1000; m_last2 = -1000;
            if (mode == 2'b01) m_phase = PH_PLAY;
         end
         PH_PLAY: begin
            if (c1) begin m_l1--; m_last1 = m_cyc; end
            if (c2) begin m_l2--; m_last2 = m_cyc; end
            if (m_l1 == 0 && m_l2 == 0) begin
               m_draw = 1; m_l1 = L; m_l2 = L; m_last1 = -1000; m_last2 = -1000;
            end else if (m_l1 == 0) begin
               m_phase = PH_P2W; m_scr = 2;
            end else if (m_l2 == 0) begin
               m_phase = PH_P1W; m_scr = 1;
            end else if (mode != 2'b01) begin
               m_phase = PH_IDLE; m_l1 = L; m_l2 = L; m_last1 = -1000; m_last2 = -1000;
            end
         end
         PH_P1W, PH_P2W: begin
            if (reset_plyrScrn) begin m_phase = PH_DONE; m_scr = 0; end
         end
         default: begin
            if (mode == 2'b00) begin
               m_phase = PH_IDLE; m_l1 = L; m_l2 = L; m_last1 = -1000; m_last2 = -1000;
            end
         end
      endcase
      m_prev1 = hit_p1;
      m_prev2 = hit_p2;
   endfunction

   task automatic tick();
      if (reset) model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_in(input logic [1:0] md, input logic h1, input logic h2, input logic ak);
      mode = md; hit_p1 = h1; hit_p2 = h2; reset_plyrScrn = ak;
   endtask

   task automatic check_out(input string tag, input int l1, input int l2, input int scr, input int drw);
      check({tag, "_lives_p1"}, 32'(lives_p1), 32'(l1));
      check({tag, "_lives_p2"}, 32'(lives_p2), 32'(l2));
      check({tag, "_screen"}, 32'(player_screen), 32'(scr));
      check({tag, "_draw"}, 32'(round_draw), 32'(drw));
   endtask

   task automatic check_model(input string tag);
      check_out(tag, m_l1, m_l2, m_scr, m_draw);
   endtask

   typedef struct {
      int         cycles;
      logic [1:0] md;
      logic       h1, h2, ak;
      int         l1, l2, scr, drw;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [1:0] md, input logic h1, input logic h2,
                               input logic ak, input int l1, input int l2, input int scr, input int drw);
      vec_t v;
      v.cycles = n; v.md = md; v.h1 = h1; v.h2 = h2; v.ak = ak;
      v.l1 = l1; v.l2 = l2; v.scr = scr; v.drw = drw;
      return v;
   endfunction

   vec_t vq[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Directed table, applied straight after reset.
      vq.push_back(mk( 1, 2'b01, 0, 0, 0, 3, 3, 0, 0));   // enter PLAY
      vq.push_back(mk( 1, 2'b01, 0, 1, 0, 3, 2, 0, 0));   // first p2 hit
      vq.push_back(mk(19, 2'b01, 0, 0, 0, 3, 2, 0, 0));
      vq.push_back(mk( 1, 2'b01, 0, 1, 0, 3, 1, 0, 0));
      vq.push_back(mk(19, 2'b01, 0, 0, 0, 3, 1, 0, 0));
      vq.push_back(mk( 1, 2'b01, 0, 1, 0, 3, 0, 1, 0));   // player 1 wins
      vq.push_back(mk( 3, 2'b00, 0, 0, 0, 3, 0, 1, 0));   // mode ignored before ack
      vq.push_back(mk( 1, 2'b00, 0, 0, 1, 3, 0, 0, 0));   // ack clears screen
      vq.push_back(mk( 1, 2'b00, 0, 0, 1, 3, 3, 0, 0));   // menu reloads lives
      vq.push_back(mk( 1, 2'b01, 0, 0, 0, 3, 3, 0, 0));   // new round
      vq.push_back(mk( 1, 2'b01, 1, 0, 0, 2, 3, 0, 0));   // holdoff: cycle 0 counts
      vq.push_back(mk( 4, 2'b01, 0, 0, 0, 2, 3, 0, 0));
      vq.push_back(mk( 1, 2'b01, 1, 0, 0, 2, 3, 0, 0));   // cycle 5 ignored
      vq.push_back(mk(11, 2'b01, 0, 0, 0, 2, 3, 0, 0));
      vq.push_back(mk( 1, 2'b01, 1, 0, 0, 1, 3, 0, 0));   // cycle 17 counts
      vq.push_back(mk( 1, 2'b01, 0, 0, 0, 1, 3, 0, 0));
      vq.push_back(mk( 1, 2'b01, 0, 1, 0, 1, 2, 0, 0));
      vq.push_back(mk(17, 2'b01, 0, 0, 0, 1, 2, 0, 0));
      vq.push_back(mk( 1, 2'b01, 0, 1, 0, 1, 1, 0, 0));
      vq.push_back(mk(17, 2'b01, 0, 0, 0, 1, 1, 0, 0));
      vq.push_back(mk( 1, 2'b01, 1, 1, 0, 3, 3, 0, 1));   // draw
      vq.push_back(mk( 1, 2'b01, 1, 1, 0, 3, 3, 0, 0));   // draw is one cycle
      vq.push_back(mk( 1, 2'b01, 0, 0, 0, 3, 3, 0, 0));
      vq.push_back(mk(40, 2'b01, 1, 0, 0, 2, 3, 0, 0));   // held high counts once
      vq.push_back(mk( 1, 2'b01, 0, 0, 0, 2, 3, 0, 0));
      vq.push_back(mk( 1, 2'b10, 0, 0, 0, 3, 3, 0, 0));   // mode leaves PLAY
      vq.push_back(mk( 1, 2'b00, 0, 0, 0, 3, 3, 0, 0));
      vq.push_back(mk( 1, 2'b01, 1, 0, 0, 3, 3, 0, 0));   // hit while still IDLE ignored
      vq.push_back(mk( 1, 2'b01, 1, 0, 0, 3, 3, 0, 0));
      vq.push_back(mk( 1, 2'b01, 0, 0, 0, 3, 3, 0, 0));

      m_cyc = 0;
      reset = 1'b0;
      set_in(2'b00, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 3, 3, 0, 0);
      reset = 1'b1;

      foreach (vq[i]) begin
         set_in(vq[i].md, vq[i].h1, vq[i].h2, vq[i].ak);
         run(vq[i].cycles);
         check_out($sformatf("vec%0d", i), vq[i].l1, vq[i].l2, vq[i].scr, vq[i].drw);
      end

      // Reset mid-game with player 1 on one life.
      set_in(2'b01, 1, 0, 0); tick();
      set_in(2'b01, 0, 0, 0); run(17);
      set_in(2'b01, 1, 0, 0); tick();
      set_in(2'b01, 0, 0, 0); tick();
      check_out("pre_rst", 1, 3, 0, 0);
      reset = 1'b0;
      #2;
      check_out("rst_mid_game", 3, 3, 0, 0);
      model_reset();
      tick();
      reset = 1'b1;

      // Player 2 wins, then reset while the win screen is shown.
      set_in(2'b01, 0, 0, 0); tick();
      for (int k = 0; k < 3; k++) begin
         set_in(2'b01, 1, 0, 0); tick();
         set_in(2'b01, 0, 0, 0); run(18);
      end
      check_out("p2_win", 0, 3, 2, 0);
      set_in(2'b11, 0, 0, 0); run(3);
      check_out("p2_win_hold", 0, 3, 2, 0);
      reset = 1'b0;
      #2;
      check_out("rst_win", 3, 3, 0, 0);
      model_reset();
      tick();
      reset = 1'b1;

      // Randomized play against the reference model.
      set_in(2'b01, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
         hit_p1         = ($urandom_range(0, 5) == 0);
         hit_p2         = ($urandom_range(0, 5) == 0);
         reset_plyrScrn = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 799) == 0) begin
            reset = 1'b0;
            #2;
            model_reset();
            check_model($sformatf("rnd_rst%0d", c));
            tick();
            reset = 1'b1;
         end
         tick();
         check_model($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
# score_keeper

Score and win-detection stage that sits directly upstream of the switch interface. It counts tank hits for both players during the game screen, enforces a post-hit holdoff, and drives the `player_screen` code that selects a win screen and raises the PicoBlaze interrupt. It clears that code when the switch interface returns `reset_plyrScrn`, and re-arms once the menu (first screen) is shown again.

## Interface
Parameters:
- `LIVES`, default 3: lives loaded per player at round start; legal range 1..15.
- `HIT_HOLDOFF`, default 16: cycles after a counted hit during which further hits on that player are ignored; legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset; asynchronous, active-low.
- `mode`  in  2  screen selector from the switch interface: 00 first screen, 01 game, 10 P1-win, 11 P2-win.
- `hit_p1`  in  1  level, high while player 1's tank is touched by a shell.
- `hit_p2`  in  1  level, high while player 2's tank is touched by a shell.
- `reset_plyrScrn`  in  1  acknowledge from the switch interface; high while a win screen is displayed.
- `player_screen`  out  2  00 no result, 01 player 1 wins, 10 player 2 wins; never 11.
- `lives_p1`  out  4  remaining lives, player 1.
- `lives_p2`  out  4  remaining lives, player 2.
- `round_draw`  out  1  one-cycle pulse when both players lose their last life on the same edge.

## Operation
- States: IDLE, PLAY, P1WIN, P2WIN, DONE.
- IDLE:
  - lives held at `LIVES`; holdoff counters at 0.
  - `mode`==01 → PLAY on the next edge.
- Hit qualification:
  - a hit is a rising edge of `hit_pX`, detected against a registered copy of the input.
  - It counts only in PLAY and only while that player's holdoff counter is 0.
  - A counted hit decrements `lives_pX` by 1 and loads the holdoff counter with `HIT_HOLDOFF`. The counter then decrements once per cycle down to 0.
  - Hits outside PLAY are ignored, but the edge register still updates.
- PLAY:
  - Player 1's lives reach 0 → P2WIN, `player_screen`=10.
  - Player 2's lives reach 0 → P1WIN, `player_screen`=01.
  - Both reach 0 on the same edge:
    - no winner; `round_draw` pulses for 1 cycle.
    - Both lives reload to `LIVES`, holdoffs clear, state stays PLAY.
  - Counted hits on both players on the same edge with lives > 1: both decrement independently.
  - `mode` leaves 01 without a winner → IDLE and lives reload.
- P1WIN/P2WIN:
  - `player_screen` and the lives values are held.
  - `reset_plyrScrn`==1 → DONE, `player_screen`=00.
  - `mode` changes are ignored until the acknowledge arrives.
- DONE:
  - `player_screen`=00; lives are held for display.
  - `mode`==00 → IDLE and lives reload to `LIVES`.
  - DONE does not depend on `reset_plyrScrn` returning low.
- Lives never underflow: a decrement at 0 is impossible, because PLAY is left on the same edge that lives reach 0.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - state IDLE; `player_screen`=00; `round_draw`=0.
  - `lives_p1`=`lives_p2`=`LIVES`; holdoff counters and edge registers 0.
- Reset deassertion takes effect at the first `clk` edge after `reset` rises.
- Reset mid-game or mid-win-screen returns to the reset values immediately.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Hit latency: `hit_pX` goes 0→1 before edge N → `lives_pX` changes after edge N.
- Win latency: a final hit at edge N → `player_screen` valid after edge N, the same edge as lives reaching 0.
- Holdoff: a hit counted at edge N → the next hit on that player can count at edge N+`HIT_HOLDOFF`+1 at the earliest.
- Acknowledge: `reset_plyrScrn` seen high at edge M → `player_screen`=00 after edge M.
- Game entry: `mode`=01 at edge K → PLAY after edge K; a hit edge at K+1 counts.

## Test plan
- Reset, then `mode`=01: `lives_p1`=`lives_p2`=3 and `player_screen`=00 throughout.
- Three separated 1-cycle `hit_p2` pulses, 20 cycles apart: `lives_p2` goes 2, 1, 0; `player_screen`=01 after the third hit edge.
- Acknowledge, then re-arm: `reset_plyrScrn`=1 → `player_screen`=00 next cycle. Then `mode`=00 → lives reload to 3. Then `mode`=01 → new round accepted.
- `hit_p1` pulses at cycles 0, 5 and 17 with `HIT_HOLDOFF`=16: only the cycle-0 and cycle-17 pulses count; `lives_p1`=1. A `hit_p1` held high for 40 cycles counts once.
- Both players at 1 life, `hit_p1` and `hit_p2` rising on the same edge: `round_draw` pulses once, both lives become 3, `player_screen` stays 00.
- Reset mid-game: drop `reset` low with `lives_p1`=1, `mode`=01 → immediate return to 3/3/00. `mode`=10 leaving PLAY mid-round → IDLE, lives 3/3.
